// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller: register map,
// blank code and the hex-to-segment table.
package hex_display_pkg;

   localparam logic [2:0] ADDR_DIGITS_LO = 3'd0;
   localparam logic [2:0] ADDR_DIGITS_HI = 3'd1;
   localparam logic [2:0] ADDR_BLANK     = 3'd2;
   localparam logic [2:0] ADDR_BLINK     = 3'd3;
   localparam logic [2:0] ADDR_DP        = 3'd4;
   localparam logic [2:0] ADDR_BLINK_DIV = 3'd5;
   localparam logic [2:0] ADDR_CTRL      = 3'd6;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low g..a patterns indexed by nibble value
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_display_ctrl_hex7seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_LUT[nib];

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM hex display controller with blank, blink and dp masks.
// Leading-zero blanking is built when HEX_DISPLAY_LZB_EN is defined.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int          NUM_DIGITS        = 8,
   parameter int unsigned DEFAULT_BLINK_DIV = 32'd25000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [2:0]              address,
   input  logic                    write,
   input  logic [31:0]             writedata,
   input  logic                    read,
   output logic [31:0]             readdata,
   output logic [NUM_DIGITS*8-1:0] hex_seg_n
);

   localparam int ND = NUM_DIGITS;

   logic [4*ND-1:0] digits_q, digits_d;
   logic [ND-1:0]   blank_q, blank_d;
   logic [ND-1:0]   blink_q, blink_d;
   logic [ND-1:0]   dp_q, dp_d;
   logic [ND-1:0]   sup;
   logic [31:0]     div_q, div_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     rd_val, ctrl_rd;
   logic            phase_q, phase_d;
   logic [8*ND-1:0] seg_q, seg_d;
   logic [63:0]     dig_full;
   logic            wr_lo, wr_hi, div_wr;
   logic [6:0]      dec_seg [ND];

   assign dig_full = 64'(digits_q);
   assign wr_lo    = write && (address == ADDR_DIGITS_LO);
   assign wr_hi    = write && (address == ADDR_DIGITS_HI);
   assign div_wr   = write && (address == ADDR_BLINK_DIV);

   always_comb begin
      digits_d = digits_q;
      blank_d  = blank_q;
      blink_d  = blink_q;
      dp_d     = dp_q;
      div_d    = div_q;
      // Digits 0..7 come from the low word, 8..15 from the high word
      for (int k = 0; k < ND; k++) begin
         if ((k < 8) ? wr_lo : wr_hi)
            digits_d[4*k+:4] = writedata[(4*k)%32+:4];
      end
      if (write) begin
         unique case (1'b1)
            address == ADDR_BLANK:     blank_d = writedata[ND-1:0];
            address == ADDR_BLINK:     blink_d = writedata[ND-1:0];
            address == ADDR_DP:        dp_d    = writedata[ND-1:0];
            address == ADDR_BLINK_DIV: div_d   = writedata;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         address == ADDR_DIGITS_LO: rd_val = dig_full[31:0];
         address == ADDR_DIGITS_HI: rd_val = dig_full[63:32];
         address == ADDR_BLANK:     rd_val = 32'(blank_q);
         address == ADDR_BLINK:     rd_val = 32'(blink_q);
         address == ADDR_DP:        rd_val = 32'(dp_q);
         address == ADDR_BLINK_DIV: rd_val = div_q;
         address == ADDR_CTRL:      rd_val = ctrl_rd;
         default: ;
      endcase
      rdata_d = read ? rd_val : rdata_q;
   end

   always_comb begin
      cnt_d   = cnt_q + 32'd1;
      phase_d = phase_q;
      if (div_wr || (div_q == 32'd0)) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == div_q - 32'd1) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

`ifdef HEX_DISPLAY_LZB_EN
   logic lzb_q, lzb_d, zrun;

   always_comb begin
      lzb_d = lzb_q;
      if (write && (address == ADDR_CTRL))
         lzb_d = writedata[0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lzb_q <= 1'b0;
      else          lzb_q <= lzb_d;
   end

   // Zero run from the top digit down; digit 0 always stays visible
   always_comb begin
      zrun = lzb_q;
      sup  = '0;
      for (int k = ND - 1; k > 0; k--) begin
         zrun   = zrun && (digits_q[4*k+:4] == 4'd0);
         sup[k] = zrun;
      end
   end

   assign ctrl_rd = {31'd0, lzb_q};
`else
   assign sup     = '0;
   assign ctrl_rd = '0;
`endif

   for (genvar g = 0; g < ND; g++) begin : g_dec
      hex7seg_decode u_dec (
         .nib   (digits_q[4*g+:4]),
         .seg_n (dec_seg[g])
      );
   end

   always_comb begin
      seg_d = '1;
      for (int k = 0; k < ND; k++) begin
         if (blank_q[k] || sup[k] || (blink_q[k] && phase_q))
            seg_d[8*k+:8] = SEG_OFF;
         else
            seg_d[8*k+:8] = {~dp_q[k], dec_seg[k]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digits_q <= '0;
         blank_q  <= '0;
         blink_q  <= '0;
         dp_q     <= '0;
         div_q    <= 32'(DEFAULT_BLINK_DIV);
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         rdata_q  <= '0;
         seg_q    <= '1;
      end else begin
         digits_q <= digits_d;
         blank_q  <= blank_d;
         blink_q  <= blink_d;
         dp_q     <= dp_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         rdata_q  <= rdata_d;
         seg_q    <= seg_d;
      end
   end

   assign readdata  = rdata_q;
   assign hex_seg_n = seg_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl (8 digits).
// Leading-zero checks run when HEX_DISPLAY_LZB_EN is defined.
module tb_hex_display_ctrl;

   localparam int ND = 8;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   logic          clk;
   logic          reset_n;
   logic [2:0]    address;
   logic          write;
   logic [31:0]   writedata;
   logic          read;
   logic [31:0]   readdata;
   logic [8*ND-1:0] hex_seg_n;

   int checks;
   int failures;

   hex_display_ctrl #(
      .NUM_DIGITS        (ND),
      .DEFAULT_BLINK_DIV (32'd25000000)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .read      (read),
      .readdata  (readdata),
      .hex_seg_n (hex_seg_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge clk);
      write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      read    = 1'b1;
      @(negedge clk);
      read    = 1'b0;
      d       = readdata;
   endtask

   function automatic logic [7:0] dig(input int k);
      return hex_seg_n[8*k+:8];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [12];
      logic [31:0] r;
      int          ph;

      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      address   = '0;
      write     = 1'b0;
      writedata = '0;
      read      = 1'b0;

      tbl[0]  = '{3'd0, 32'h12345678, 32'h12345678};
      tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000000};
      tbl[2]  = '{3'd2, 32'hFFFFFFFF, 32'h000000FF};
      tbl[3]  = '{3'd3, 32'h0001A5A5, 32'h000000A5};
      tbl[4]  = '{3'd4, 32'h0000FF3C, 32'h0000003C};
      tbl[5]  = '{3'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[6]  = '{3'd6, 32'hFFFFFFFE, 32'h00000000};
      tbl[7]  = '{3'd7, 32'hFFFFFFFF, 32'h00000000};
      tbl[8]  = '{3'd2, 32'h00000000, 32'h00000000};
      tbl[9]  = '{3'd3, 32'h00000000, 32'h00000000};
      tbl[10] = '{3'd4, 32'h00000000, 32'h00000000};
      tbl[11] = '{3'd5, 32'd25000000, 32'd25000000};

      repeat (2) @(negedge clk);
      chk("reset_seg", hex_seg_n, {64{1'b1}});
      chk("reset_rdata", readdata, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("first_edge_c0", hex_seg_n, 64'hC0C0C0C0C0C0C0C0);
      rd(3'd5, r);
      chk("rst_blink_div", r, 32'd25000000);

      for (int i = 0; i < 12; i++) begin
         wr(tbl[i].addr, tbl[i].wd);
         rd(tbl[i].addr, r);
         chk($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), r, tbl[i].exp);
      end
      chk("seg_12345678", hex_seg_n, 64'hF9A4B0999282F880);

      address   = 3'd0;
      writedata = 32'hCAFEF00D;
      write     = 1'b1;
      read      = 1'b1;
      @(negedge clk);
      write     = 1'b0;
      read      = 1'b0;
      chk("rd_wr_old", readdata, 32'h12345678);
      rd(3'd0, r);
      chk("rd_wr_new", r, 32'hCAFEF00D);

      wr(3'd0, 32'h89ABCDEF);
      wr(3'd4, 32'h00000001);
      @(negedge clk);
      chk("seg_89abcdef_dp0", hex_seg_n, 64'h80908883C6A1860E);
      rd(3'd0, r);
      chk("rb_digits_lo", r, 32'h89ABCDEF);

      wr(3'd3, 32'h00000003);
      wr(3'd5, 32'd4);
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         ph = ((j - 1) / 4) % 2;
         chk($sformatf("blink_d0_%0d", j), dig(0), ph ? 8'hFF : 8'h0E);
         chk($sformatf("blink_d1_%0d", j), dig(1), ph ? 8'hFF : 8'h86);
      end
      wr(3'd5, 32'd0);
      chk("freeze_lag_d0", dig(0), 8'hFF);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk($sformatf("frozen_d0_%0d", j), dig(0), 8'h0E);
         chk($sformatf("frozen_d1_%0d", j), dig(1), 8'h86);
      end

      wr(3'd5, 32'd4);
      wr(3'd2, 32'h00000080);
      wr(3'd3, 32'h00000080);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk($sformatf("blank7_%0d", j), dig(7), 8'hFF);
         chk($sformatf("steady0_%0d", j), dig(0), 8'h0E);
      end
      wr(3'd1, 32'h12345678);
      rd(3'd1, r);
      chk("digits_hi_rb", r, 32'h0);
      wr(3'd2, 32'h0);
      wr(3'd3, 32'h0);
      wr(3'd4, 32'h0);

`ifdef HEX_DISPLAY_LZB_EN
      wr(3'd6, 32'h00000001);
      wr(3'd0, 32'h00000120);
      @(negedge clk);
      chk("lzb_120", hex_seg_n, 64'hFFFFFFFFFFF9A4C0);
      rd(3'd6, r);
      chk("lzb_ctrl_rb", r, 32'h1);
      wr(3'd4, 32'h000000FF);
      @(negedge clk);
      chk("lzb_dp", hex_seg_n, 64'hFFFFFFFFFF792440);
      wr(3'd4, 32'h0);
      wr(3'd0, 32'h0);
      @(negedge clk);
      chk("lzb_zero", hex_seg_n, 64'hFFFFFFFFFFFFFFC0);
      wr(3'd6, 32'h0);
      @(negedge clk);
      chk("lzb_off", hex_seg_n, 64'hC0C0C0C0C0C0C0C0);
`endif

      wr(3'd0, 32'h89ABCDEF);
      wr(3'd3, 32'h00000003);
      rd(3'd5, r);
      chk("pend_rdata", r, 32'd4);
      repeat (5) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_seg", hex_seg_n, {64{1'b1}});
      chk("async_rst_rdata", readdata, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_c0", hex_seg_n, 64'hC0C0C0C0C0C0C0C0);
      rd(3'd5, r);
      chk("post_rst_div", r, 32'd25000000);
      rd(3'd3, r);
      chk("post_rst_blink", r, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment digits directly from hexadecimal nibbles.
- Replaces one raw-segment PIO per digit with a single register-mapped block.
- Adds per-digit blanking, blinking with a programmable rate, and decimal-point control.
- Sits inside the Nios system; its segment bus is exported to the board HEX pins.

Parameters:
- NUM_DIGITS, 8, number of digits driven; legal range 1..16.
- DEFAULT_BLINK_DIV, 25000000, reset value of BLINK_DIV (0.5 s half-period at 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  Avalon word address
- write  in  1  write strobe
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data, fixed read latency 1
- hex_seg_n  out  NUM_DIGITS*8  segments, active-low; digit k occupies [8k+7:8k]; bit 7 = dp, bits 6..0 = g..a

Behaviour:
- Register map (word address, reset value):
  - 0 DIGITS_LO: nibbles for digits 0..7, digit k at [4k+3:4k]; reset 0.
  - 1 DIGITS_HI: digits 8..15; reset 0.
  - 2 BLANK: mask [15:0]; reset 0.
  - 3 BLINK: mask [15:0]; reset 0.
  - 4 DP: mask [15:0], 1 = dp lit; reset 0.
  - 5 BLINK_DIV: 32-bit half-period in clk cycles; reset DEFAULT_BLINK_DIV.
  - 6 CTRL: see Optional Feature.
  - 7: reserved.
- Bits for digits at or above NUM_DIGITS are not stored: writes are ignored and reads return 0. Reserved addresses read 0 and ignore writes.
- Writes take effect on the clk edge where write=1.
- readdata is registered: valid the cycle after read=1 and holds until the next read. A read and write to the same address in one cycle returns the old value.
- Blink timer:
  - 32-bit counter increments each cycle. When it equals BLINK_DIV-1 it clears and blink_phase toggles.
  - BLINK_DIV=0 holds the counter at 0 and blink_phase at 0.
  - Any write to BLINK_DIV clears the counter and blink_phase in the same edge.
- Per-digit output, evaluated in priority order:
  - BLANK[k], or (BLINK[k] and blink_phase=1): 8'hFF.
  - Otherwise: {~DP[k], decode(nibble)}.
- Decode, active-low g..a:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- hex_seg_n is registered. It reflects register state with one-cycle latency: a write at edge N is visible after edge N+1.
- Reset:
  - hex_seg_n = all ones (all segments off).
  - readdata = 0, counter = 0, blink_phase = 0, all registers at the reset values above.
  - The first edge after reset release drives "0" with dp off (8'hC0) on every digit.
- Reset asserted mid-operation clears everything asynchronously, including a pending readdata.

Optional Feature:
- Macro: HEX_DISPLAY_LZB_EN.
- Defined:
  - CTRL[0] enables leading-zero blanking.
  - Scanning from digit NUM_DIGITS-1 downward, each digit whose nibble is 0 is forced blank until the first non-zero nibble is reached.
  - Digit 0 is never blanked by this rule.
  - The DP bit of a suppressed digit is also suppressed.
  - CTRL reads back [0]; other bits read 0.
- Undefined: CTRL reads 0, writes are ignored, no suppression logic is built.

Decomposition:
- Package hex_display_pkg:
  - Register offset constants (ADDR_DIGITS_LO..ADDR_CTRL).
  - SEG_OFF = 8'hFF.
  - 16-entry decode table constant.
- Sub-module hex7seg_decode: nibble in, 7-bit active-low segment out (combinational). Instantiated NUM_DIGITS times with a generate loop.

Test Plan:
- Reset, then idle 2 cycles:
  - During reset, hex_seg_n = all FF.
  - After the first edge, every digit = 8'hC0.
  - Read addr 5 returns 25000000.
- Write DIGITS_LO=32'h89ABCDEF, DP=16'h0001:
  - Two edges later, digit0 = 0x0E (F with dp lit), digit7 = 0x80.
  - Readback of addr 0 returns 32'h89ABCDEF.
- Write BLINK_DIV=4, BLINK=16'h0003:
  - Digits 1:0 alternate between decoded value and FF every 4 cycles.
  - Writing BLINK_DIV=0 mid-blink freezes them at the decoded value.
- Write BLANK=16'h0080, BLINK=16'h0080 (digit 7):
  - Digit 7 stays FF in both blink phases.
  - Writes to DIGITS_HI with NUM_DIGITS=8 read back 0.
- HEX_DISPLAY_LZB_EN defined, CTRL=1, DIGITS_LO=32'h00000120:
  - Digits 7..3 = FF; digit2 = 0xF9 ("1"), digit1 = 0xA4 ("2"), digit0 = 0xC0 ("0").
  - With DIGITS_LO=0, only digit0 shows 0xC0.
- Assert reset_n mid-blink with readdata pending:
  - All outputs return to reset values immediately.
  - BLINK_DIV reads back 25000000 after release.
